agat9_kbd_receiver: RTL
=======================

AGAT9_KBD_RECEIVER -- requirements
Module: agat9_kbd_receiver

Interface
REQ-001 Parameter CLK_DIV, default 8, meaning system clocks per half period of kbd_clock (legal range 4..255).
REQ-002 Parameter FLOW, default 1, meaning 1 = kbd_reply used for flow control, 0 = kbd_reply held 0.
REQ-003 clock  input  1  system clock; the block uses one clock only, all flops on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 kbd_clock  output  1  keyboard shift clock ("Гкл") driven to the keyboard.
REQ-006 kbd_reply  output  1  transfer hold ("Ответ"): 0 = keyboard may shift, 1 = hold.
REQ-007 key_data  input  1  serial data from the keyboard, asynchronous, idle high.
REQ-008 kbd_reset_n  input  1  keyboard reset key line ("Сброс"), asynchronous, active low.
REQ-009 rus_lat_in  input  1  keyboard Russian/Latin line, asynchronous.
REQ-010 code  output  7  last accepted key code.
REQ-011 code_valid  output  1  code holds an unread value.
REQ-012 code_ack  input  1  host consumed code; sampled when code_valid = 1.
REQ-013 overrun  output  1  sticky flag: a frame was dropped because code was unread.
REQ-014 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-015 host_reset  output  1  debounced reset request to the host, active high.
REQ-016 rus_lat  output  1  synchronized rus_lat_in.

Function
REQ-017 Divider counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps and toggles kbd_clock, giving period 2*CLK_DIV; first rise is CLK_DIV cycles after reset release.
REQ-018 key_data, kbd_reset_n and rus_lat_in each pass a 2-flop synchronizer; key_data and kbd_reset_n synchronizers reset to 1, rus_lat_in to 0.
REQ-019 Sample strobe is the cycle in which kbd_clock toggles 1->0; the synchronized key_data value in that cycle is the sampled bit.
REQ-020 Frame is a start bit 0, then 7 data bits LSB first, then a stop bit 1, one bit per kbd_clock period.
REQ-021 FSM states are IDLE, DATA, STOP and RESYNC, with the following transitions:
  - IDLE: a sampled 0 moves to DATA with bit counter = 0.
  - DATA: shift in each sampled bit; after bit 6, move to STOP.
  - STOP: a sampled 1 accepts the frame and moves to IDLE; a sampled 0 pulses frame_err for one cycle and moves to RESYNC.
  - RESYNC: a sampled 1 moves to IDLE; a 0 stays in RESYNC.
REQ-022 On accept, code and code_valid update on the cycle after the stop strobe, i.e. latency 1 clock from the stop sample.
REQ-023 An accept while code_valid = 1 and code_ack = 0 drops the new code (code unchanged) and sets overrun.
REQ-024 code_ack with code_valid = 1 clears code_valid and overrun on the next cycle; code_ack with code_valid = 0 is ignored.
REQ-025 If code_ack and an accept occur in the same cycle, the new code is loaded, code_valid stays 1 and overrun is not set.
REQ-026 If FLOW = 1, kbd_reply = code_valid, but kbd_reply may change only while the FSM is in IDLE; mid-frame it holds its value.
REQ-027 A frame_err does not alter code, code_valid or overrun.
REQ-028 host_reset asserts after synchronized kbd_reset_n has been 0 for 16 consecutive clocks; it deasserts after 16 consecutive clocks at 1; any shorter run restarts the filter count.
REQ-029 rus_lat = synchronized rus_lat_in, with 2-clock latency.

Reset
REQ-030 While reset_n = 0, the following values hold:
  - kbd_clock, kbd_reply, code, code_valid, overrun, frame_err, host_reset and rus_lat are all 0;
  - FSM is in IDLE, divider and bit counter are 0, and the debounce filter is cleared.
REQ-031 reset_n asserted mid-frame aborts the frame with no output side effect; after release the block behaves as after power-up.

Verification
REQ-032 CLK_DIV=4, release reset -> all outputs 0, kbd_clock first rises 4 clocks later, period 8 clocks.
REQ-033 Send frame 0x41 -> code=0x41 and code_valid=1 one clock after the stop strobe; kbd_reply=1; pulse code_ack -> code_valid=0, kbd_reply=0.
REQ-034 0x41 unread, then send 0x2A -> code stays 0x41, overrun=1; code_ack -> code_valid=0, overrun=0.
REQ-035 Frame 0x15 with stop bit 0, line held 0 for 3 more samples, then 1, then frame 0x33 -> one frame_err pulse, no 0x15, then code=0x33.
REQ-036 kbd_reset_n low 10 clocks -> host_reset stays 0; low 20 clocks -> host_reset=1 18 clocks after the falling edge (2 sync + 16 filter).
REQ-037 Assert reset_n after 3 data bits, release, send 0x7F -> code=0x7F, code_valid=1, frame_err never pulses.

Source files
------------

// File: rtl/agat9_kbd_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// agat9_kbd_receiver
//
// Receiver for the Agat-9 serial keyboard. The block generates the keyboard
// shift clock and samples one bit per clock period, on the 1->0 toggle. A frame
// is a start bit 0, seven data bits LSB first and a stop bit 1. An accepted
// frame is held for the host until the host acknowledges it. The keyboard
// reset key is debounced, and the Russian/Latin line is resynchronized.
//
// Parameters
//   CLK_DIV     system clocks per half period of kbd_clock (4..255)
//   FLOW        1: kbd_reply tells the keyboard to hold; 0: kbd_reply is always 0
//
// Ports
//   clock       in   system clock (rising edge)
//   reset_n     in   asynchronous active-low reset
//   kbd_clock   out  shift clock to the keyboard
//   kbd_reply   out  transfer hold to the keyboard (1 = hold)
//   key_data    in   serial data from the keyboard, idle high (asynchronous)
//   kbd_reset_n in   keyboard reset key, active low (asynchronous)
//   rus_lat_in  in   Russian/Latin line (asynchronous)
//   code        out  [6:0] last accepted key code
//   code_valid  out  code holds an unread value
//   code_ack    in   host consumed code
//   overrun     out  sticky: a frame was dropped because code was unread
//   frame_err   out  one-cycle pulse on a bad stop bit
//   host_reset  out  debounced reset request, active high
//   rus_lat     out  synchronized rus_lat_in
// -----------------------------------------------------------------------------
module agat9_kbd_receiver #(
  parameter int CLK_DIV = 8,
  parameter int FLOW    = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic       kbd_clock,
  output logic       kbd_reply,
  input  logic       key_data,
  input  logic       kbd_reset_n,
  input  logic       rus_lat_in,
  output logic [6:0] code,
  output logic       code_valid,
  input  logic       code_ack,
  output logic       overrun,
  output logic       frame_err,
  output logic       host_reset,
  output logic       rus_lat
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    STOP   = 2'd2,
    RESYNC = 2'd3
  } state_t;

  // divider and shift clock
  logic [7:0] div_q;
  logic       kclk_q;

  // two-flop synchronizers
  logic       key_s1_q, key_s2_q;
  logic       rst_s1_q, rst_s2_q;
  logic       rl_s1_q,  rl_s2_q;

  // frame FSM and host-side registers
  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [6:0] code_q,    code_d;
  logic       valid_q,   valid_d;
  logic       overrun_q, overrun_d;
  logic       reply_q,   reply_d;
  logic       frame_err_q;

  // reset-key debounce
  logic [3:0] filt_cnt_q;
  logic       host_reset_q;

  logic div_wrap;
  logic strobe;
  logic sbit;
  logic accept;
  logic ack;
  logic idle_next;

  assign div_wrap = (div_q == DIV_LAST);
  // The sample point is the edge on which kbd_clock falls.
  assign strobe   = div_wrap && kclk_q;
  assign sbit     = key_s2_q;
  assign accept   = strobe && (state_q == STOP) && sbit;
  assign ack      = code_ack && valid_q;

  // The FSM is back in IDLE after this edge; the hold line may only move then,
  // so the keyboard never sees it change in the middle of a frame.
  assign idle_next = ((state_q == IDLE) && !(strobe && !sbit)) ||
                     accept ||
                     ((state_q == RESYNC) && strobe && sbit);

  // Host-side holding register. An ack in the same cycle as an accept frees
  // the slot, so the new code is taken instead of being counted as overrun.
  always_comb begin
    code_d    = code_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (accept) begin
      if (valid_q && !code_ack) begin
        overrun_d = 1'b1;
      end else begin
        code_d  = shift_q;
        valid_d = 1'b1;
        if (ack) begin
          overrun_d = 1'b0;
        end
      end
    end else if (ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_comb begin
    reply_d = 1'b0;
    if (FLOW != 0) begin
      reply_d = idle_next ? valid_d : reply_q;
    end
  end

  // Divider and input synchronizers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= 8'd0;
      kclk_q   <= 1'b0;
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      rst_s1_q <= 1'b1;
      rst_s2_q <= 1'b1;
      rl_s1_q  <= 1'b0;
      rl_s2_q  <= 1'b0;
    end else begin
      key_s1_q <= key_data;
      key_s2_q <= key_s1_q;
      rst_s1_q <= kbd_reset_n;
      rst_s2_q <= rst_s1_q;
      rl_s1_q  <= rus_lat_in;
      rl_s2_q  <= rl_s1_q;
      if (div_wrap) begin
        div_q  <= 8'd0;
        kclk_q <= ~kclk_q;
      end else begin
        div_q  <= div_q + 8'd1;
      end
    end
  end

  // Frame FSM with its registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      code_q      <= 7'd0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      reply_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      code_q      <= code_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      reply_q     <= reply_d;
      frame_err_q <= 1'b0;
      if (strobe) begin
        case (state_q)
          IDLE: begin
            if (!sbit) begin
              state_q   <= DATA;
              bit_cnt_q <= 3'd0;
            end
          end
          DATA: begin
            // LSB arrives first, so shift in from the top.
            shift_q <= {sbit, shift_q[6:1]};
            if (bit_cnt_q == 3'd6) begin
              state_q <= STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
          STOP: begin
            if (sbit) begin
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= RESYNC;
            end
          end
          RESYNC: begin
            // Wait for the line to go idle before hunting for a start bit.
            if (sbit) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Reset-key debounce: the output follows the synchronized line only after
  // 16 consecutive clocks of disagreement; any agreeing clock restarts it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filt_cnt_q   <= 4'd0;
      host_reset_q <= 1'b0;
    end else begin
      if ((!rst_s2_q) != host_reset_q) begin
        if (filt_cnt_q == 4'd15) begin
          filt_cnt_q   <= 4'd0;
          host_reset_q <= ~host_reset_q;
        end else begin
          filt_cnt_q   <= filt_cnt_q + 4'd1;
        end
      end else begin
        filt_cnt_q <= 4'd0;
      end
    end
  end

  assign kbd_clock  = kclk_q;
  assign kbd_reply  = reply_q;
  assign code       = code_q;
  assign code_valid = valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign host_reset = host_reset_q;
  assign rus_lat    = rl_s2_q;

endmodule
